// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store unit of the multicycle CPU:
//   - size encodings presented by the control unit on 'size'
//   - fault codes reported on 'fault_code'
//   - FSM state enum
//   - helper that sizes the WRITE wait counter from the TIMEOUT parameter
// -----------------------------------------------------------------------------
package store_pkg;

  // Store size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // Fault codes
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_SIZE     = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

  // Store FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  // Width of a counter that must be able to hold the value 'timeout'.
  // A disabled timeout (0) still gets a 1-bit counter so no zero-width
  // vectors appear.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage : store_pkg

// File: rtl/store_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
// Purely combinational lane steering for a store request. Replicates the
// right-justified store data across the byte lanes that the access size can
// land on, produces the little-endian byte enables, and classifies the
// request as illegal (size 11) or misaligned.
//
// Ports:
//   addr_lo       in   2   low two bits of the byte address
//   size          in   2   00 byte, 01 halfword, 10 word, 11 illegal
//   wdata         in  32   store data, value in the low bits
//   lane_data     out 32   lane-replicated store data
//   lane_be       out  4   byte enables, bit i = byte lane i
//   misalign      out  1   halfword on odd address, or word not on 4-byte boundary
//   illegal_size  out  1   size encoding 11
// -----------------------------------------------------------------------------
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_be,
  output logic        misalign,
  output logic        illegal_size
);

  // An illegal size never raises misalign, which gives the size check
  // priority without a separate priority mux downstream.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned; otherwise synthesis infers a latch.
    lane_data    = wdata;
    lane_be      = 4'b0000;
    misalign     = 1'b0;
    illegal_size = 1'b0;

    case (size)
      SZ_BYTE: begin
        lane_data = {4{wdata[7:0]}};
        lane_be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        lane_data = {2{wdata[15:0]}};
        lane_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign  = addr_lo[0];
      end
      SZ_WORD: begin
        lane_data = wdata;
        lane_be   = 4'b1111;
        misalign  = (addr_lo != 2'b00);
      end
      default: begin
        illegal_size = 1'b1;
      end
    endcase
  end

endmodule : store_lane_align

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Write-side counterpart of the memory data register. Accepts a byte,
// halfword or word store from the control unit, turns it into a single
// aligned, byte-enabled word write, and holds that write on the memory port
// until memory acknowledges it. Completion is reported with a one-cycle
// 'done' pulse; a rejected request or a memory timeout with a one-cycle
// 'fault' pulse plus a sticky 'fault_code'.
//
// Parameters:
//   ADDR_W   address width (data path fixed at 32 bits / 4 byte lanes)
//   TIMEOUT  max WRITE cycles waiting for mem_ready; 0 disables the timeout
//
// Ports:
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high; clears all state
//   start       in   1       store request, sampled only in IDLE
//   addr        in   ADDR_W  byte address of the store
//   wdata       in   32      store data, right-justified
//   size        in   2       00 byte, 01 half, 10 word, 11 illegal
//   mem_addr    out  ADDR_W  word-aligned write address
//   mem_wdata   out  32      lane-replicated write data
//   mem_be      out  4       byte enables, bit i = lane i
//   mem_we      out  1       write request, held until acknowledged
//   mem_ready   in   1       memory acknowledge
//   busy        out  1       high while in WRITE
//   done        out  1       one-cycle pulse after a successful write
//   fault       out  1       one-cycle pulse on a rejected or timed-out store
//   fault_code  out  2       00 none, 01 misaligned, 10 size, 11 timeout
// -----------------------------------------------------------------------------
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  // Counter value seen during the last allowed WRITE cycle. When the
  // counter holds this value and memory is still not ready, that edge is
  // the one that ends the store, so mem_we was high for exactly TIMEOUT
  // cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              done_d;
  logic              fault_d;
  logic [1:0]        code_d;
  logic              load;

  logic [31:0]       lane_data;
  logic [3:0]        lane_be;
  logic              misalign;
  logic              illegal_size;

  // ---------------------------------------------------------------------------
  // Lane steering and request classification
  // ---------------------------------------------------------------------------
  store_lane_align u_align (
    .addr_lo      (addr[1:0]),
    .size         (size),
    .wdata        (wdata),
    .lane_data    (lane_data),
    .lane_be      (lane_be),
    .misalign     (misalign),
    .illegal_size (illegal_size)
  );

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    code_d     = fault_code;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (illegal_size || misalign) begin
            // Rejected: stay idle, report next cycle, memory port untouched.
            fault_d = 1'b1;
            code_d  = illegal_size ? FLT_SIZE : FLT_MISALIGN;
          end else begin
            load       = 1'b1;
            code_d     = FLT_NONE;
            wait_cnt_d = '0;
            state_d    = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        // An acknowledge always wins, including in the final allowed cycle.
        if (mem_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (wait_cnt_q == TO_LAST)) begin
            fault_d = 1'b1;
            code_d  = FLT_TIMEOUT;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait counter and status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      done       <= done_d;
      fault      <= fault_d;
      fault_code <= code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-port datapath registers, loaded only on an accepted start so they
  // stay stable for the whole WRITE phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: these datapath registers are reset on purpose: the memory port
      // must show a defined all-zero address, data and byte-enable pattern
      // out of reset, not whatever the flops powered up with.
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (load) begin
      mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
      mem_wdata <= lane_data;
      mem_be    <= lane_be;
    end
  end

  // Both are straight decodes of the state flop; the async reset of that
  // flop drops mem_we the moment reset rises.
  assign mem_we = (state_q == ST_WRITE);
  assign busy   = (state_q == ST_WRITE);

endmodule : store_unit

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Scoreboard bench for store_unit (TIMEOUT = 4). The driver computes the
// expected outcome of each store from a behavioural model and pushes it into
// a queue; an independent monitor pops and compares whenever the DUT pulses
// done or fault, and tracks the write phase on the memory port.
// -----------------------------------------------------------------------------
module tb_store_unit;
  import store_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;

  always #5 clk = ~clk;

  store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr       (addr),
    .wdata      (wdata),
    .size       (size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code)
  );

  typedef struct {
    bit          is_fault;
    logic [1:0]  code;
    int          we_cycles;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome of one store given the number of cycles memory
  // keeps mem_ready low before acknowledging (w).
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sz, input int w);
    exp_t e;
    e.is_fault  = 1'b0;
    e.code      = 2'd0;
    e.we_cycles = 0;
    e.addr      = a & 32'hFFFF_FFFC;
    e.data      = 32'd0;
    e.be        = 4'd0;
    if (sz == 2'd3) begin
      e.is_fault = 1'b1;
      e.code     = 2'd2;
    end else if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
      e.is_fault = 1'b1;
      e.code     = 2'd1;
    end else begin
      case (sz)
        2'd0: begin
          e.data = {24'd0, d[7:0]} * 32'h0101_0101;
          e.be   = 4'(1 << a[1:0]);
        end
        2'd1: begin
          e.data = {16'd0, d[15:0]} * 32'h0001_0001;
          e.be   = (a[1:0] == 2'd2) ? 4'hC : 4'h3;
        end
        default: begin
          e.data = d;
          e.be   = 4'hF;
        end
      endcase
      if (w >= int'(TO)) begin
        e.is_fault  = 1'b1;
        e.code      = 2'd3;
        e.we_cycles = TO;
      end else begin
        e.we_cycles = w + 1;
      end
    end
    return e;
  endfunction

  // Issue one store. Entered and left just after a falling edge, so calls
  // can be chained back-to-back. During the write phase start is toggled
  // with junk fields, which the DUT must ignore.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input int w);
    exp_t e;
    e = model(a, d, sz, w);
    sb.push_back(e);
    start     = 1'b1;
    addr      = a;
    wdata     = d;
    size      = sz;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int i = 1; i <= e.we_cycles; i++) begin
      @(negedge clk);
      mem_ready = (i == w + 1);
      start     = 1'($urandom_range(0, 1));
      addr      = $urandom;
      wdata     = $urandom;
      size      = 2'($urandom_range(0, 3));
      @(posedge clk);
    end
    @(negedge clk);
    start     = 1'b0;
    mem_ready = 1'b0;
    if (e.is_fault) check("fault_latency", {31'd0, fault}, 32'd1);
    else            check("done_latency", {31'd0, done}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int          wcnt = 0;
  bit          stable;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic [3:0]  cap_be;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      wcnt = 0;
    end else begin
      if (mem_we) begin
        if (wcnt == 0) begin
          cap_addr = mem_addr;
          cap_data = mem_wdata;
          cap_be   = mem_be;
          stable   = 1'b1;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_data || mem_be !== cap_be) begin
          stable = 1'b0;
        end
        wcnt++;
      end
      if (mem_we || busy) check("busy_vs_we", {31'd0, busy}, {31'd0, mem_we});
      if (done || fault) begin
        check("done_fault_exclusive", {31'd0, done && fault}, 32'd0);
        check("we_low_at_end", {31'd0, mem_we}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_outcome: done=%0b fault=%0b with no store pending at %0t",
                   done, fault, $time);
        end else begin
          e = sb.pop_front();
          check("outcome_fault", {31'd0, fault}, {31'd0, e.is_fault});
          check("fault_code", {30'd0, fault_code}, {30'd0, e.code});
          check("we_cycles", wcnt, e.we_cycles);
          if (e.we_cycles > 0) begin
            check("mem_addr", cap_addr, e.addr);
            check("mem_wdata", cap_data, e.data);
            check("mem_be", {28'd0, cap_be}, {28'd0, e.be});
            check("port_stable", {31'd0, stable}, 32'd1);
          end
        end
        wcnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    reset     = 1'b1;
    start     = 1'b0;
    addr      = '0;
    wdata     = '0;
    size      = '0;
    mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_code", {30'd0, fault_code}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(32'h0000_0100, 32'hDEAD_BEEF, SZ_WORD, 0);
    issue(32'h0000_0203, 32'h0000_00A5, SZ_BYTE, 0);
    issue(32'h0000_0011, 32'h0000_1234, SZ_HALF, 0);
    issue(32'h0000_0011, 32'h0000_1234, SZ_BAD, 0);
    issue(32'h0000_0012, 32'h0000_BEEF, SZ_HALF, 1);
    issue(32'h0000_0402, 32'hCAFE_F00D, SZ_WORD, 0);
    issue(32'h0000_0040, 32'h1122_3344, SZ_WORD, 3);
    issue(32'h0000_0044, 32'h5566_7788, SZ_WORD, 9);
    @(negedge clk);
    check("fault_code_hold", {30'd0, fault_code}, {30'd0, FLT_TIMEOUT});
    check("fault_pulse_single", {31'd0, fault}, 32'd0);
    issue(32'h0000_0048, 32'h0BAD_F00D, SZ_WORD, 0);

    // Reset in the second WRITE cycle abandons the store
    start     = 1'b1;
    addr      = 32'h0000_0300;
    wdata     = 32'h1234_5678;
    size      = SZ_WORD;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_write_we", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_we", {31'd0, mem_we}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_be", {28'd0, mem_be}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(32'h0000_0500, 32'hA5A5_5A5A, SZ_WORD, 0);

    // Randomized stores, often back-to-back
    for (int t = 0; t < 200; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_WORD) a[1:0] = 2'b00;
        if (sz == SZ_HALF) a[0]   = 1'b0;
      end
      issue(a, $urandom, sz, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_store_unit

// File: doc/store_unit.md
# store_unit

Write-side counterpart of the memory data register in the multicycle CPU. The control unit issues a store of a byte, halfword or word. This block turns it into one aligned, byte-enabled word write on the memory port and holds the request until memory acknowledges it. It reports completion to the control FSM, or a fault for a misaligned address, an illegal size or a memory timeout.

## Interface
Parameters:
- ADDR_W, 32, address width; data path fixed at 32 bits, 4 byte lanes
- TIMEOUT, 16, max WRITE cycles waiting for mem_ready; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  store request; sampled only in IDLE
- addr  in  ADDR_W  byte address of the store
- wdata  in  32  store data, right-justified (value in low bits)
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables, bit i = lane i (little-endian)
- mem_we  out  1  write request, held until acknowledged
- mem_ready  in  1  memory acknowledge; handshake completes on a clk edge with mem_we and mem_ready both high
- busy  out  1  high in WRITE state
- done  out  1  one-cycle pulse after a successful write
- fault  out  1  one-cycle pulse on a rejected or timed-out store
- fault_code  out  2  00 none, 01 misaligned, 10 illegal size, 11 timeout

## Operation
- States: IDLE, WRITE.
- IDLE, start=0: no action.
- IDLE, start=1, request legal: register address, lane data and byte enables; go to WRITE.
- IDLE, start=1, request illegal: stay in IDLE; pulse fault next cycle.
  - size=11 gives fault_code=10.
  - Half with addr[0]=1 gives 01.
  - Word with addr[1:0]≠00 gives 01.
  - The illegal-size check takes priority over the misaligned check.
- Lane rules:
  - Byte: mem_wdata = {4{wdata[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - Half: mem_wdata = {2{wdata[15:0]}}, mem_be = addr[1] ? 1100 : 0011.
  - Word: mem_wdata = wdata, mem_be = 1111.
- WRITE:
  - mem_we=1. mem_addr, mem_wdata and mem_be are stable throughout.
  - If mem_ready=1 at an edge, go to IDLE and pulse done.
  - A wait counter increments on each WRITE cycle with mem_ready=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT, go to IDLE and pulse fault with code 11. mem_we was then high for exactly TIMEOUT cycles.
  - If mem_ready=1 in the final allowed cycle, the write counts as success, not timeout.
- start while busy: ignored, no queueing.
- fault_code holds its last value until the next accepted start, which clears it to 00.
- done and fault are never high in the same cycle.
- Reset mid-WRITE: mem_we drops immediately (async); the store is abandoned, with no done and no fault.

## Timing
- Reset values:
  - Control/status: state IDLE, mem_we 0, busy 0, done 0, fault 0, fault_code 00.
  - Datapath: mem_addr 0, mem_wdata 0, mem_be 0000, wait counter 0.
- start at edge N (legal): mem_we and busy high from cycle N+1.
- mem_ready high at edge N+k: done high during cycle N+k+1; mem_we and busy low in the same cycle. Minimum latency from start to done is 2 cycles.
- In the done or fault cycle the state is already IDLE, so a new start is accepted. This gives back-to-back stores at one per 2 cycles with a zero-wait memory.
- Illegal start at edge N: fault high during cycle N+1; mem_we never asserted.
- All outputs are registered; no combinational path from start or mem_ready to any output.

## Structure
- Shared package (store_pkg): size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), fault codes (FLT_NONE, FLT_MISALIGN, FLT_SIZE, FLT_TIMEOUT), state enum.
- One combinational sub-module, store_lane_align:
  - Inputs: addr[1:0], size, wdata.
  - Outputs: lane data, byte enables, misalign/illegal flags.
- The FSM, wait counter and output registers live in store_unit.

## Test plan
- Word store: addr=0x100, wdata=0xDEADBEEF, mem_ready tied 1 -> mem_we for 1 cycle, mem_addr=0x100, mem_be=1111, done at cycle 2.
- Byte store: addr=0x203, wdata=0x000000A5 -> mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5.
- Half misaligned: addr=0x11, size=01 -> fault pulse with code 01, mem_we never high. Same with size=11 -> code 10.
- Wait states: mem_ready low for 3 cycles, then high -> mem_we high 4 cycles, outputs stable, single done pulse. A start issued while busy is ignored.
- Timeout: TIMEOUT=4, mem_ready never high -> mem_we high exactly 4 cycles, then fault with code 11. Next start clears fault_code to 00.
- Reset asserted in the second WRITE cycle -> mem_we, busy and mem_be 0 immediately; no done. After release, a fresh word store completes normally.
